noc_output_scheduler: RTL and testbench

Per-output-port scheduler for the NoC router. It shares one router output port among the input buffers (default five) and picks one eligible head flit per cycle using round-robin priority. It drives the matching buffer's `pop`, registers the chosen flit onto the output link, and tracks downstream free space with credits so the next-hop input buffer never overflows. It keeps a shadow occupancy count for each input buffer, because the buffers expose only their head flit and carry no empty flag.

---
 rtl/noc_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/noc_output_scheduler.sv | 86 ++++++++
 tb/tb_noc_output_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, buffer sizing and output-port target codes.
package noc_pkg;

  localparam int FLIT_W      = 23;
  localparam int PAYLOAD_MSB = 22;
  localparam int PAYLOAD_LSB = 7;
  localparam int ADDR_MSB    = 6;
  localparam int ADDR_LSB    = 3;
  localparam int TGT_MSB     = 2;
  localparam int TGT_LSB     = 0;
  localparam int TGT_W       = TGT_MSB - TGT_LSB + 1;

  localparam int BUF_DEPTH   = 5;

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NORTH = 3'd1;
  localparam logic [2:0] PORT_EAST  = 3'd2;
  localparam logic [2:0] PORT_SOUTH = 3'd3;
  localparam logic [2:0] PORT_WEST  = 3'd4;

  function automatic logic [TGT_W-1:0] flit_tgt(input logic [FLIT_W-1:0] f);
    return f[TGT_MSB:TGT_LSB];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from ptr, pointer
// advances past the winner on every grant.
module rr_arbiter #(
  parameter int N = 5,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] ptr_nxt;
  logic          any_gnt;
  int            idx;

  always_comb begin
    gnt     = '0;
    any_gnt = 1'b0;
    gidx    = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        any_gnt  = 1'b1;
        gidx     = PW'(idx);
      end
    end
    ptr_nxt = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ptr <= '0;
    else if (any_gnt) ptr <= ptr_nxt;
  end

endmodule

// File: rtl/noc_output_scheduler.sv
// One router output port: shadow-counts each input buffer, round-robin grants a
// matching head flit while downstream credits remain, and registers it onto the link.
module noc_output_scheduler
  import noc_pkg::*;
#(
  parameter int         N_IN      = 5,
  parameter logic [2:0] PORT_ID   = 3'd0,
  parameter int         FLIT_W    = noc_pkg::FLIT_W,
  parameter int         BUF_DEPTH = noc_pkg::BUF_DEPTH,
  parameter int         CREDITS   = 5,
  localparam int        CW        = $clog2(CREDITS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          in_wr,
  input  logic [N_IN*FLIT_W-1:0]   in_head,
  output logic [N_IN-1:0]          pop,
  output logic [FLIT_W-1:0]        out_flit,
  output logic                     out_valid,
  input  logic                     credit_in,
  output logic [CW-1:0]            credits,
  output logic                     err
);

  localparam int NW = $clog2(BUF_DEPTH + 1);

  logic [NW-1:0]     cnt [N_IN];
  logic [N_IN-1:0]   nz;
  logic [N_IN-1:0]   req;
  logic [FLIT_W-1:0] sel;
  logic              grant;
  logic              en;

  always_comb begin
    nz  = '0;
    req = '0;
    sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      nz[i]  = (cnt[i] != '0);
      req[i] = nz[i] && (in_head[i*FLIT_W + TGT_LSB +: 3] == PORT_ID);
      if (pop[i]) sel = in_head[i*FLIT_W +: FLIT_W];
    end
  end

  assign en    = (credits != '0);
  assign grant = |pop;

  rr_arbiter #(.N(N_IN)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req & {N_IN{en}}),
    .gnt (pop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
      credits   <= CW'(CREDITS);
      out_valid <= 1'b0;
      out_flit  <= '0;
      err       <= 1'b0;
    end else begin
      // Saturating shadow counters; write+pop together leaves the count alone.
      for (int i = 0; i < N_IN; i++) begin
        case ({in_wr[i], pop[i]})
          2'b10:   if (cnt[i] == NW'(BUF_DEPTH)) err <= 1'b1;
                   else cnt[i] <= cnt[i] + 1'b1;
          2'b01:   if (cnt[i] == '0) err <= 1'b1;
                   else cnt[i] <= cnt[i] - 1'b1;
          default: ;
        endcase
      end
      case ({grant, credit_in})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   if (credits == CW'(CREDITS)) err <= 1'b1;
                 else credits <= credits + 1'b1;
        default: ;
      endcase
      out_valid <= grant;
      if (grant) out_flit <= sel;
    end
  end

  a_no_pop_underflow: assert property (@(posedge clk) disable iff (!rst) (pop & ~nz) == '0);

endmodule

// File: tb/tb_noc_output_scheduler.sv
// Directed bench for noc_output_scheduler (PORT_ID=0, 5 inputs, 5 credits).
module tb_noc_output_scheduler;

  localparam int N  = 5;
  localparam int FW = 23;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_wr;
  logic [N*FW-1:0] in_head;
  logic [N-1:0]    pop;
  logic [FW-1:0]   out_flit;
  logic            out_valid;
  logic            credit_in;
  logic [2:0]      credits;
  logic            err;

  int errors = 0;
  int checks = 0;
  int nvalid;

  noc_output_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .in_wr     (in_wr),
    .in_head   (in_head),
    .pop       (pop),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .credit_in (credit_in),
    .credits   (credits),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic [15:0] p, input logic [3:0] a, input logic [2:0] t);
    return {p, a, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_wr     = '0;
    credit_in = 1'b0;
    rst       = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    in_head = '0;
    do_reset();
    rst = 1'b0;
    #1;
    chk("rst_pop", 32'(pop), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_flit", 32'(out_flit), 32'h0);
    chk("rst_credits", 32'(credits), 32'd5);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b1;

    // single flit through input 2
    in_head[2*FW +: FW] = mk(16'hBEEF, 4'h3, 3'd0);
    in_wr = 5'b00100;
    tick();
    in_wr = '0;
    #1;
    chk("single_pop", 32'(pop), 32'b00100);
    chk("single_cnt", 32'(dut.cnt[2]), 32'd1);
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_flit", 32'(out_flit), 32'(mk(16'hBEEF, 4'h3, 3'd0)));
    chk("single_credits", 32'(credits), 32'd4);
    chk("single_pop_after", 32'(pop), 32'h0);
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_flit_hold", 32'(out_flit), 32'(mk(16'hBEEF, 4'h3, 3'd0)));

    // contention among inputs 0, 1, 3 from ptr=0
    do_reset();
    in_head[0*FW +: FW] = mk(16'h1000, 4'h1, 3'd0);
    in_head[1*FW +: FW] = mk(16'h1111, 4'h2, 3'd0);
    in_head[3*FW +: FW] = mk(16'h3333, 4'h4, 3'd0);
    in_wr = 5'b01011;
    tick();
    in_wr = '0;
    #1;
    chk("cont_pop0", 32'(pop), 32'b00001);
    tick();
    chk("cont_flit0", 32'(out_flit), 32'(mk(16'h1000, 4'h1, 3'd0)));
    chk("cont_pop1", 32'(pop), 32'b00010);
    tick();
    chk("cont_flit1", 32'(out_flit), 32'(mk(16'h1111, 4'h2, 3'd0)));
    chk("cont_pop3", 32'(pop), 32'b01000);
    tick();
    chk("cont_flit3", 32'(out_flit), 32'(mk(16'h3333, 4'h4, 3'd0)));
    chk("cont_valid3", 32'(out_valid), 32'd1);
    chk("cont_pop_none", 32'(pop), 32'h0);
    chk("cont_credits", 32'(credits), 32'd2);
    chk("cont_ptr", 32'(dut.u_arb.ptr), 32'd4);

    // non-matching target on input 0
    in_head[0*FW +: FW] = mk(16'h0BAD, 4'h0, 3'd1);
    in_wr = 5'b00001;
    tick();
    in_wr = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("nomatch_pop", 32'(pop), 32'h0);
      tick();
    end
    chk("nomatch_cnt", 32'(dut.cnt[0]), 32'd1);
    chk("nomatch_valid", 32'(out_valid), 32'd0);

    // credit stall: 7 flits queued (5 on input 1, 2 on input 2), only 5 credits
    do_reset();
    in_head[1*FW +: FW] = mk(16'hAAAA, 4'h5, 3'd0);
    in_head[2*FW +: FW] = mk(16'h5555, 4'h6, 3'd0);
    nvalid = 0;
    for (int c = 0; c < 15; c++) begin
      in_wr = {2'b00, (c < 2), (c < 5), 1'b0};
      tick();
      if (out_valid) nvalid++;
    end
    in_wr = '0;
    chk("stall_count", 32'(nvalid), 32'd5);
    chk("stall_credits", 32'(credits), 32'd0);
    chk("stall_pop", 32'(pop), 32'h0);
    chk("stall_cnt1", 32'(dut.cnt[1]), 32'd2);
    chk("stall_cnt2", 32'(dut.cnt[2]), 32'd0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    #1;
    chk("release_credits", 32'(credits), 32'd1);
    chk("release_pop", 32'(pop), 32'b00010);
    nvalid = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) nvalid++;
    end
    chk("release_count", 32'(nvalid), 32'd1);
    chk("release_credits_end", 32'(credits), 32'd0);
    chk("release_cnt1", 32'(dut.cnt[1]), 32'd1);

    // write+pop and grant+credit in the same cycle
    do_reset();
    in_head[3*FW +: FW] = mk(16'h7777, 4'h7, 3'd0);
    in_wr = 5'b01000;
    tick();
    chk("simul_pop_a", 32'(pop), 32'b01000);
    tick();
    chk("simul_cnt_hold", 32'(dut.cnt[3]), 32'd1);
    chk("simul_credits_a", 32'(credits), 32'd4);
    in_wr = '0;
    credit_in = 1'b1;
    #1;
    chk("simul_pop_b", 32'(pop), 32'b01000);
    tick();
    credit_in = 1'b0;
    chk("simul_credits_hold", 32'(credits), 32'd4);
    chk("simul_cnt_drain", 32'(dut.cnt[3]), 32'd0);

    // shadow-count overflow on input 4 (target not served here)
    do_reset();
    in_head[4*FW +: FW] = mk(16'h4444, 4'h8, 3'd2);
    in_wr = 5'b10000;
    for (int c = 0; c < 5; c++) tick();
    chk("ovf_err_before", 32'(err), 32'd0);
    chk("ovf_cnt_full", 32'(dut.cnt[4]), 32'd5);
    tick();
    in_wr = '0;
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_cnt_sat", 32'(dut.cnt[4]), 32'd5);

    // credit overflow
    do_reset();
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("cred_ovf_credits", 32'(credits), 32'd5);
    chk("cred_ovf_err", 32'(err), 32'd1);

    // async reset in the middle of a burst (err still set from above)
    for (int i = 0; i < N; i++) in_head[i*FW +: FW] = mk(16'(i + 16'h900), 4'(i), 3'd0);
    in_wr = 5'b11111;
    tick();
    in_wr = '0;
    tick();
    tick();
    chk("burst_valid", 32'(out_valid), 32'd1);
    chk("burst_credits", 32'(credits), 32'd3);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_credits", 32'(credits), 32'd5);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_pop", 32'(pop), 32'h0);
    chk("arst_flit", 32'(out_flit), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_pop", 32'(pop), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
